bp_me_lce_latency_monitor: RTL and testbench
============================================

# bp_me_lce_latency_monitor

Synthesizable, parametrised request-latency profiler for the LCE-CCE interface. It watches the request-header handshake and the cache-request-complete strobe of `num_lce_p` LCEs. Per LCE it times each coherent request and accumulates count, sum, min, max, a latency histogram and a protocol-error count. The statistics are readable through a registered one-cycle read port. It sits beside the LCEs in the ME tile, and firmware or bench code samples it at run time.

## Interface
- `num_lce_p`, 2: number of monitored LCE channels (≥1).
- `cnt_width_p`, 32: width of every accumulator and of `rd_data_o`.
- `lat_width_p`, 16: width of the per-channel latency timer.
- `hist_bins_p`, 8: histogram bins per channel (power of two, ≥2).
- `bin_shift_p`, 2: latency right-shift used for bin index.
- `sel_width_lp` (local): `$clog2(5+hist_bins_p)`.
- `lg_num_lce_lp` (local): `BSG_SAFE_CLOG2(num_lce_p)`.

Ports:
- `clk_i`, in, 1: single clock, all state on rising edge.
- `reset_n_i`, in, 1: reset, asynchronous, active-low.
- `enable_i`, in, 1: gates statistic updates only; FSMs always track.
- `clear_i`, in, 1: synchronous clear of all stats and FSMs.
- `req_v_i`, in, `num_lce_p`: LCE request header valid, per channel.
- `req_ready_and_i`, in, `num_lce_p`: request header ready, per channel.
- `req_uc_wr_i`, in, `num_lce_p`: request is an uncached store (not timed).
- `complete_i`, in, `num_lce_p`: cache_req_complete pulse, per channel.
- `busy_o`, out, `num_lce_p`: channel has a timed request outstanding.
- `rd_v_i`, in, 1: read request.
- `rd_lce_i`, in, `lg_num_lce_lp`: channel to read.
- `rd_sel_i`, in, `sel_width_lp`: 0=count, 1=sum, 2=min, 3=max, 4=error, 5+b=histogram bin b.
- `rd_v_o`, out, 1: read data valid.
- `rd_data_o`, out, `cnt_width_p`: read data.

## Operation
- Handshake on channel c: `req_v_i[c] & req_ready_and_i[c]`. The request is timed only if `req_uc_wr_i[c]`=0.
- Per-channel FSM has two states, IDLE and BUSY.
  - IDLE + timed handshake: go to BUSY, timer←1.
  - BUSY, no complete: timer←timer+1, saturating at 2^lat_width_p−1.
  - BUSY + complete: record latency L=timer and go to IDLE.
  - BUSY + complete + timed handshake in the same cycle: record L, then stay BUSY with timer←1.
  - BUSY + timed handshake without complete: error+1, timer keeps running, no restart.
  - IDLE + complete: error+1, no record.
  - IDLE + handshake + complete in the same cycle: treat as handshake only, plus error+1.
  - Untimed handshake (uc store): no FSM effect in any state.
- Record of L (only when `enable_i`=1):
  - count+1 and sum+L (L zero-extended).
  - min←min(min,L) and max←max(max,L).
  - bin[min(L>>bin_shift_p, hist_bins_p−1)]+1.
- Every accumulator saturates at all-ones and never wraps. Error counting is also gated by `enable_i`.
- min resets to all-ones. A read of min with count=0 returns all-ones.
- `clear_i`: all stats go to reset values and all FSMs to IDLE with timer 0, on the next edge. clear_i has priority over any same-cycle handshake or complete.
- Read port:
  - `rd_v_i` at cycle t gives `rd_v_o`=1 and `rd_data_o` at t+1.
  - Returned value is the pre-edge value at t, so a same-cycle update is not visible.
  - Out-of-range `rd_lce_i` or `rd_sel_i` returns 0.
  - `rd_data_o` holds its last value while `rd_v_o`=0.

## Timing
- Reset (reset_n_i=0, asynchronous):
  - `busy_o`=0, `rd_v_o`=0, `rd_data_o`=0.
  - timers, count, sum, max, error and bins = 0; min = all-ones; FSMs IDLE.
  - Reset asserted mid-request discards the request with no record.
- `busy_o[c]` is registered: high the cycle after the handshake, low the cycle after the complete.
- Latency definition: handshake at edge t, complete sampled at edge t+k gives L=k. Minimum L=1.
- Stats update on the edge that samples complete, and are visible to a read issued the following cycle.
- Channels are fully independent; simultaneous events on different channels all record in the same cycle.

## Test plan
- Ch0 timed handshake, complete 5 cycles later -> count=1, sum=5, min=5, max=5, bin1=1 (bin_shift 2). `busy_o[0]` high for 5 cycles.
- Ch1 latencies 3, 40, 7 -> count=3, sum=50, min=3, max=40; bin0=1, bin1=1, bin7=1 (40>>2=10 clamps to 7).
- Ch0 complete + new handshake in the same cycle, then complete 2 cycles later -> two records, the second with L=2; busy stays high across the boundary.
- Ch0 complete while IDLE, then a handshake while BUSY -> error=2, count unchanged. With enable_i=0 the same events leave every stat unchanged.
- cnt_width_p=4: 16 requests of L=1 -> count=15 and sum=15, both saturated. clear_i then gives count 0 and min 0xF.
- reset_n_i low mid-request on ch1, async at a non-edge time -> `busy_o`=0 immediately; a read after release returns count=0. A uc-store handshake leaves `busy_o`=0.

Source files
------------

// File: rtl/bp_me_lce_latency_monitor.sv
// bp_me_lce_latency_monitor: per-LCE coherent request latency profiler
// (count/sum/min/max/histogram/errors) behind a registered read port.
module bp_me_lce_latency_monitor #(
  parameter int num_lce_p   = 2,
  parameter int cnt_width_p = 32,
  parameter int lat_width_p = 16,
  parameter int hist_bins_p = 8,
  parameter int bin_shift_p = 2,
  localparam int sel_width_lp  = $clog2(5 + hist_bins_p),
  localparam int lg_num_lce_lp = (num_lce_p == 1) ? 1 : $clog2(num_lce_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [num_lce_p-1:0]     req_v_i,
  input  logic [num_lce_p-1:0]     req_ready_and_i,
  input  logic [num_lce_p-1:0]     req_uc_wr_i,
  input  logic [num_lce_p-1:0]     complete_i,
  output logic [num_lce_p-1:0]     busy_o,
  input  logic                     rd_v_i,
  input  logic [lg_num_lce_lp-1:0] rd_lce_i,
  input  logic [sel_width_lp-1:0]  rd_sel_i,
  output logic                     rd_v_o,
  output logic [cnt_width_p-1:0]   rd_data_o
);

  localparam int lp_bw = $clog2(hist_bins_p);
  localparam int lp_sw =
    ((cnt_width_p > lat_width_p) ? cnt_width_p : lat_width_p) + 1;
  localparam logic [cnt_width_p-1:0] lp_cmax = '1;
  localparam logic [lat_width_p-1:0] lp_lmax = '1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e                 r_state   [num_lce_p];
  state_e                 w_state_n [num_lce_p];
  logic [lat_width_p-1:0] r_timer   [num_lce_p];
  logic [lat_width_p-1:0] w_timer_n [num_lce_p];
  logic [cnt_width_p-1:0] r_cnt     [num_lce_p];
  logic [cnt_width_p-1:0] w_cnt_n   [num_lce_p];
  logic [cnt_width_p-1:0] r_sum     [num_lce_p];
  logic [cnt_width_p-1:0] w_sum_n   [num_lce_p];
  logic [cnt_width_p-1:0] r_min     [num_lce_p];
  logic [cnt_width_p-1:0] w_min_n   [num_lce_p];
  logic [cnt_width_p-1:0] r_max     [num_lce_p];
  logic [cnt_width_p-1:0] w_max_n   [num_lce_p];
  logic [cnt_width_p-1:0] r_err     [num_lce_p];
  logic [cnt_width_p-1:0] w_err_n   [num_lce_p];
  logic [cnt_width_p-1:0] r_bin     [num_lce_p][hist_bins_p];
  logic [cnt_width_p-1:0] w_bin_n   [num_lce_p][hist_bins_p];

  logic [lp_sw-1:0]       w_lx      [num_lce_p];
  logic [lp_sw-1:0]       w_sx      [num_lce_p];
  logic [cnt_width_p-1:0] w_lc      [num_lce_p];
  logic [cnt_width_p-1:0] w_sum_sat [num_lce_p];
  logic [lat_width_p-1:0] w_sh      [num_lce_p];
  logic [lp_bw-1:0]       w_idx     [num_lce_p];

  logic [num_lce_p-1:0]   w_hs;
  logic [num_lce_p-1:0]   w_rec;
  logic [num_lce_p-1:0]   w_err;

  logic                    r_rd_v;
  logic [cnt_width_p-1:0]  r_rd_data;
  logic [cnt_width_p-1:0]  w_rd_data;
  logic [sel_width_lp-1:0] w_boff;

  function automatic logic [cnt_width_p-1:0] f_inc(
    input logic [cnt_width_p-1:0] v
  );
    return (v == lp_cmax) ? v : v + cnt_width_p'(1);
  endfunction

  assign w_hs = req_v_i & req_ready_and_i & ~req_uc_wr_i;

  // Latency-derived values, clamped into the accumulator width
  always_comb begin
    for (int c = 0; c < num_lce_p; c++) begin
      w_lx[c] = lp_sw'(r_timer[c]);
      w_sx[c] = lp_sw'(r_sum[c]) + w_lx[c];
      w_lc[c] = (w_lx[c] > lp_sw'(lp_cmax)) ?
                lp_cmax : w_lx[c][cnt_width_p-1:0];
      w_sum_sat[c] = (w_sx[c] > lp_sw'(lp_cmax)) ?
                     lp_cmax : w_sx[c][cnt_width_p-1:0];
      w_sh[c] = r_timer[c] >> bin_shift_p;
      w_idx[c] = (w_sh[c] >= lat_width_p'(hist_bins_p - 1)) ?
                 lp_bw'(hist_bins_p - 1) : w_sh[c][lp_bw-1:0];
    end
  end

  always_comb begin
    w_rec = '0;
    w_err = '0;
    for (int c = 0; c < num_lce_p; c++) begin
      w_state_n[c] = r_state[c];
      w_timer_n[c] = r_timer[c];
      w_cnt_n[c]   = r_cnt[c];
      w_sum_n[c]   = r_sum[c];
      w_min_n[c]   = r_min[c];
      w_max_n[c]   = r_max[c];
      w_err_n[c]   = r_err[c];
      for (int b = 0; b < hist_bins_p; b++)
        w_bin_n[c][b] = r_bin[c][b];

      unique case (r_state[c])
        S_IDLE: begin
          if (w_hs[c]) begin
            w_state_n[c] = S_BUSY;
            w_timer_n[c] = lat_width_p'(1);
          end
          w_err[c] = complete_i[c];
        end
        S_BUSY: begin
          if (complete_i[c]) begin
            w_rec[c] = 1'b1;
            if (w_hs[c]) begin
              w_timer_n[c] = lat_width_p'(1);
            end else begin
              w_state_n[c] = S_IDLE;
              w_timer_n[c] = '0;
            end
          end else begin
            w_err[c] = w_hs[c];
            if (r_timer[c] != lp_lmax)
              w_timer_n[c] = r_timer[c] + lat_width_p'(1);
          end
        end
        default: ;
      endcase

      if (enable_i && w_rec[c]) begin
        w_cnt_n[c] = f_inc(r_cnt[c]);
        w_sum_n[c] = w_sum_sat[c];
        if (w_lc[c] < r_min[c]) w_min_n[c] = w_lc[c];
        if (w_lc[c] > r_max[c]) w_max_n[c] = w_lc[c];
        w_bin_n[c][w_idx[c]] = f_inc(r_bin[c][w_idx[c]]);
      end
      if (enable_i && w_err[c])
        w_err_n[c] = f_inc(r_err[c]);

      // Clear overrides every same-cycle event
      if (clear_i) begin
        w_state_n[c] = S_IDLE;
        w_timer_n[c] = '0;
        w_cnt_n[c]   = '0;
        w_sum_n[c]   = '0;
        w_min_n[c]   = '1;
        w_max_n[c]   = '0;
        w_err_n[c]   = '0;
        for (int b = 0; b < hist_bins_p; b++)
          w_bin_n[c][b] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < num_lce_p; c++) begin
        r_state[c] <= S_IDLE;
        r_timer[c] <= '0;
        r_cnt[c]   <= '0;
        r_sum[c]   <= '0;
        r_min[c]   <= '1;
        r_max[c]   <= '0;
        r_err[c]   <= '0;
        for (int b = 0; b < hist_bins_p; b++)
          r_bin[c][b] <= '0;
      end
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      for (int c = 0; c < num_lce_p; c++) begin
        r_state[c] <= w_state_n[c];
        r_timer[c] <= w_timer_n[c];
        r_cnt[c]   <= w_cnt_n[c];
        r_sum[c]   <= w_sum_n[c];
        r_min[c]   <= w_min_n[c];
        r_max[c]   <= w_max_n[c];
        r_err[c]   <= w_err_n[c];
        for (int b = 0; b < hist_bins_p; b++)
          r_bin[c][b] <= w_bin_n[c][b];
      end
      r_rd_v <= rd_v_i;
      if (rd_v_i) r_rd_data <= w_rd_data;
    end
  end

  always_comb begin
    for (int c = 0; c < num_lce_p; c++)
      busy_o[c] = (r_state[c] == S_BUSY);
    w_boff    = rd_sel_i - sel_width_lp'(5);
    w_rd_data = '0;
    if (int'(rd_lce_i) < num_lce_p) begin
      unique case (1'b1)
        (rd_sel_i == sel_width_lp'(0)): w_rd_data = r_cnt[rd_lce_i];
        (rd_sel_i == sel_width_lp'(1)): w_rd_data = r_sum[rd_lce_i];
        (rd_sel_i == sel_width_lp'(2)): w_rd_data = r_min[rd_lce_i];
        (rd_sel_i == sel_width_lp'(3)): w_rd_data = r_max[rd_lce_i];
        (rd_sel_i == sel_width_lp'(4)): w_rd_data = r_err[rd_lce_i];
        (int'(rd_sel_i) >= 5 &&
         int'(rd_sel_i) < 5 + hist_bins_p):
          w_rd_data = r_bin[rd_lce_i][w_boff[lp_bw-1:0]];
        default: w_rd_data = '0;
      endcase
    end
  end

  assign rd_v_o    = r_rd_v;
  assign rd_data_o = r_rd_data;

endmodule

// File: tb/tb_bp_me_lce_latency_monitor.sv
// Scoreboard bench: reads are predicted from a cycle-stamped latency model,
// a monitor pops and compares whenever rd_v_o is presented.
module tb_bp_me_lce_latency_monitor;

  localparam int N  = 2;
  localparam int CW = 32;
  localparam int HB = 8;
  localparam int BS = 2;
  localparam longint CMAXV = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n_i = 1'b0;
  logic          enable_i = 1'b1;
  logic          clear_i = 1'b0;
  logic [N-1:0]  req_v_i = '0;
  logic [N-1:0]  req_ready_and_i = '0;
  logic [N-1:0]  req_uc_wr_i = '0;
  logic [N-1:0]  complete_i = '0;
  logic [N-1:0]  busy_o;
  logic          rd_v_i = 1'b0;
  logic [0:0]    rd_lce_i = '0;
  logic [3:0]    rd_sel_i = '0;
  logic          rd_v_o;
  logic [CW-1:0] rd_data_o;

  logic          b_clear = 1'b0;
  logic [0:0]    b_req_v = '0;
  logic [0:0]    b_cmp = '0;
  logic [0:0]    b_busy;
  logic          b_rd_v = 1'b0;
  logic [3:0]    b_rd_sel = '0;
  logic          b_rd_v_o;
  logic [3:0]    b_rd_data;
  logic [3:0]    b_exp = '0;

  bp_me_lce_latency_monitor dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .enable_i(enable_i),
    .clear_i(clear_i), .req_v_i(req_v_i),
    .req_ready_and_i(req_ready_and_i), .req_uc_wr_i(req_uc_wr_i),
    .complete_i(complete_i), .busy_o(busy_o), .rd_v_i(rd_v_i),
    .rd_lce_i(rd_lce_i), .rd_sel_i(rd_sel_i), .rd_v_o(rd_v_o),
    .rd_data_o(rd_data_o)
  );

  bp_me_lce_latency_monitor #(.num_lce_p(1), .cnt_width_p(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n_i), .enable_i(1'b1),
    .clear_i(b_clear), .req_v_i(b_req_v), .req_ready_and_i(b_req_v),
    .req_uc_wr_i(1'b0), .complete_i(b_cmp), .busy_o(b_busy),
    .rd_v_i(b_rd_v), .rd_lce_i(1'b0), .rd_sel_i(b_rd_sel),
    .rd_v_o(b_rd_v_o), .rd_data_o(b_rd_data)
  );

  // Reference model: unbounded totals, saturation applied when read
  longint m_cnt [N];
  longint m_sum [N];
  longint m_min [N];
  longint m_max [N];
  longint m_err [N];
  longint m_bin [N][HB];
  bit     m_busy[N];
  longint m_start[N];
  longint cyc = 0;

  longint q  [$];
  longint q2 [$];
  longint last_rd = 0;
  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t",
                  name, act, exp, $time);
  endfunction

  function automatic longint sat(longint v);
    return (v > CMAXV) ? CMAXV : v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0; m_sum[c] = 0; m_max[c] = 0; m_err[c] = 0;
      m_min[c] = 64'h7fff_ffff_ffff_ffff;
      m_busy[c] = 0; m_start[c] = 0;
      for (int b = 0; b < HB; b++) m_bin[c][b] = 0;
    end
  endfunction

  function automatic longint exp_read(int l, int s);
    if (s == 0) return sat(m_cnt[l]);
    if (s == 1) return sat(m_sum[l]);
    if (s == 2) return (m_cnt[l] == 0) ? CMAXV : sat(m_min[l]);
    if (s == 3) return sat(m_max[l]);
    if (s == 4) return sat(m_err[l]);
    if (s >= 5 && s < 5 + HB) return sat(m_bin[l][s-5]);
    return 0;
  endfunction

  function automatic void record(int c, longint lat);
    longint bi;
    m_cnt[c]++;
    m_sum[c] += lat;
    if (lat < m_min[c]) m_min[c] = lat;
    if (lat > m_max[c]) m_max[c] = lat;
    bi = lat >> BS;
    if (bi > HB - 1) bi = HB - 1;
    m_bin[c][bi]++;
  endfunction

  function automatic void model_edge();
    bit hs, cm;
    if (clear_i) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      hs = req_v_i[c] && req_ready_and_i[c] && !req_uc_wr_i[c];
      cm = complete_i[c];
      if (m_busy[c]) begin
        if (cm) begin
          if (enable_i) record(c, cyc - m_start[c]);
          if (hs) m_start[c] = cyc;
          else m_busy[c] = 0;
        end else if (hs && enable_i) m_err[c]++;
      end else begin
        if (cm && enable_i) m_err[c]++;
        if (hs) begin m_busy[c] = 1; m_start[c] = cyc; end
      end
    end
  endfunction

  // One clock: check busy, predict any read, advance model, idle inputs
  task automatic step();
    for (int c = 0; c < N; c++)
      chk($sformatf("busy%0d", c), longint'(busy_o[c]), longint'(m_busy[c]));
    if (rd_v_i) q.push_back(exp_read(int'(rd_lce_i), int'(rd_sel_i)));
    if (b_rd_v) q2.push_back(longint'(b_exp));
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    req_v_i = '0; req_ready_and_i = '0; req_uc_wr_i = '0;
    complete_i = '0; enable_i = 1'b1; clear_i = 1'b0;
    rd_v_i = 1'b0; b_clear = 1'b0; b_req_v = '0; b_cmp = '0;
    b_rd_v = 1'b0;
  endtask

  task automatic req(int c);
    req_v_i[c] = 1'b1; req_ready_and_i[c] = 1'b1;
  endtask

  task automatic lat(int c, int l);
    req(c); step();
    repeat (l - 1) step();
    complete_i[c] = 1'b1; step();
  endtask

  task automatic dump(int c);
    for (int s = 0; s < 14; s++) begin
      rd_v_i = 1'b1; rd_lce_i = 1'(c); rd_sel_i = 4'(s);
      step();
    end
  endtask

  task automatic b_read(int s, int e);
    b_rd_v = 1'b1; b_rd_sel = 4'(s); b_exp = 4'(e);
    step();
  endtask

  always @(posedge clk) begin
    #1;
    if (reset_n_i) begin
      if (rd_v_o) begin
        if (q.size() == 0) begin
          chk("rd_unexpected", longint'(rd_data_o), -1);
        end else begin
          chk("rd_data", longint'(rd_data_o), q.pop_front());
          last_rd = longint'(rd_data_o);
        end
      end else begin
        chk("rd_hold", longint'(rd_data_o), last_rd);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset_n_i && b_rd_v_o) begin
      if (q2.size() == 0) chk("rd4_unexpected", longint'(b_rd_data), -1);
      else chk("rd4_data", longint'(b_rd_data), q2.pop_front());
    end
  end

  initial begin
    int n_b;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", longint'(busy_o), 0);
    chk("reset_rd_v", longint'(rd_v_o), 0);
    chk("reset_rd_data", longint'(rd_data_o), 0);
    reset_n_i = 1'b1;
    dump(0);

    lat(0, 5);
    dump(0);
    lat(1, 3); lat(1, 40); lat(1, 7);
    dump(1);

    req(0); step();
    complete_i[0] = 1'b1; req(0); step();
    step();
    complete_i[0] = 1'b1; step();
    dump(0);

    complete_i[0] = 1'b1; step();
    req(0); step();
    req(0); step();
    complete_i[0] = 1'b1; step();
    dump(0);
    enable_i = 1'b0; complete_i[0] = 1'b1; step();
    enable_i = 1'b0; req(0); step();
    enable_i = 1'b0; req(0); step();
    enable_i = 1'b0; complete_i[0] = 1'b1; step();
    dump(0);

    req(1); req_uc_wr_i[1] = 1'b1; step();
    step();

    b_req_v = 1'b1; step();
    n_b = 16;
    for (int i = 0; i < n_b; i++) begin
      b_cmp = 1'b1; b_req_v = (i != n_b - 1); step();
    end
    b_read(0, (n_b > 15) ? 15 : n_b);
    b_read(1, (n_b > 15) ? 15 : n_b);
    b_read(2, 1);
    b_read(3, 1);
    b_clear = 1'b1; step();
    b_read(0, 0);
    b_read(2, 15);

    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        req_v_i[c] = ($urandom_range(0, 3) == 0);
        req_ready_and_i[c] = ($urandom_range(0, 1) == 0);
        req_uc_wr_i[c] = ($urandom_range(0, 7) == 0);
        complete_i[c] = m_busy[c] ? ($urandom_range(0, 9) == 0)
                                  : ($urandom_range(0, 39) == 0);
      end
      enable_i = ($urandom_range(0, 15) != 0);
      clear_i = ($urandom_range(0, 499) == 0);
      rd_v_i = ($urandom_range(0, 1) == 0);
      rd_lce_i = 1'($urandom_range(0, 1));
      rd_sel_i = 4'($urandom_range(0, 15));
      step();
    end
    dump(0);
    dump(1);

    lat(1, 2);
    req(1); step();
    step();
    #2 reset_n_i = 1'b0;
    #1;
    chk("async_busy", longint'(busy_o), 0);
    chk("async_rd_v", longint'(rd_v_o), 0);
    model_reset();
    last_rd = 0;
    @(negedge clk);
    reset_n_i = 1'b1;
    step();
    dump(1);
    repeat (2) step();

    chk("queue_empty", longint'(q.size()), 0);
    chk("queue4_empty", longint'(q2.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
